// File: rtl/dmem_arbiter.sv
// Arbiter and one-deep command sequencer between the CPU and an auxiliary master
// sharing the single-port data memory; read data is routed back to its originator.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_be,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic        aux_be,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        mem_we,
  output logic        mem_be,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic        cmd_valid;
  logic        cmd_we;
  logic        cmd_be;
  logic        cmd_src;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  wait_cnt;
  logic        aux_wins;

  // Grants are masked during reset so no requester sees a completion that is dropped.
  always_comb begin
    aux_wins = aux_req & (~cpu_req | (wait_cnt == MaxWait));
    cpu_gnt  = rst_n & cpu_req & ~aux_wins;
    aux_gnt  = rst_n & aux_wins;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (aux_gnt || !aux_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MaxWait) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_be    <= 1'b0;
      cmd_src   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      cmd_valid <= cpu_gnt | aux_gnt;
      if (aux_gnt) begin
        cmd_we    <= aux_we;
        cmd_be    <= aux_be;
        cmd_src   <= 1'b1;
        cmd_addr  <= aux_addr;
        cmd_wdata <= aux_wdata;
      end else if (cpu_gnt) begin
        cmd_we    <= cpu_we;
        cmd_be    <= cpu_be;
        cmd_src   <= 1'b0;
        cmd_addr  <= cpu_addr;
        cmd_wdata <= cpu_wdata;
      end
    end
  end

  // The memory port is idle (all zero) whenever no command is held.
  always_comb begin
    mem_we = cmd_valid & cmd_we;
    mem_be = cmd_valid & cmd_be;
    mem_a  = cmd_valid ? cmd_addr : 32'd0;
    mem_wd = cmd_valid ? cmd_wdata : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
    end else begin
      cpu_rvalid <= cmd_valid & ~cmd_we & ~cmd_src;
      aux_rvalid <= cmd_valid & ~cmd_we & cmd_src;
      if (cmd_valid && !cmd_we) begin
        if (cmd_src) begin
          aux_rdata <= mem_rd;
        end else begin
          cpu_rdata <= mem_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural dmem, reference memory and a read-response
// scoreboard filled at grant time and drained as rvalid pulses appear.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_be;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        aux_req, aux_we, aux_be;
  logic [31:0] aux_addr, aux_wdata;
  logic        cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid;
  logic [31:0] cpu_rdata, aux_rdata;
  logic        mem_we, mem_be;
  logic [31:0] mem_a, mem_wd, mem_rd;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tb_mem  [0:63];
  logic [31:0] ref_mem [0:63];
  bit          mem_loaded;
  int          n_compared = 0;
  int          n_mismatched = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_be(aux_be),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(input int i);
    return {16'hC0DE, 8'(i), 8'(i) ^ 8'h3C};
  endfunction

  // Behavioural dmem: writes commit at posedge, reads are captured at negedge.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      if (mem_be) tb_mem[mem_a[7:2]][8*mem_a[1:0] +: 8] <= mem_wd[7:0];
      else        tb_mem[mem_a[7:2]] <= mem_wd;
    end
  end

  always @(negedge clk) begin
    if (mem_be) mem_rd <= {24'd0, tb_mem[mem_a[7:2]][8*mem_a[1:0] +: 8]};
    else        mem_rd <= tb_mem[mem_a[7:2]];
  end

  function automatic logic [31:0] ref_read(input logic be, input logic [31:0] addr);
    logic [31:0] w;
    w = ref_mem[addr[7:2]];
    return be ? {24'd0, w[8*addr[1:0] +: 8]} : w;
  endfunction

  task automatic ref_write(input logic be, input logic [31:0] addr, input logic [31:0] wdata);
    if (be) ref_mem[addr[7:2]][8*addr[1:0] +: 8] = wdata[7:0];
    else    ref_mem[addr[7:2]] = wdata;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic drive_aux(input logic req, input logic we, input logic be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    aux_req = req; aux_we = we; aux_be = be; aux_addr = addr; aux_wdata = wdata;
  endtask

  task automatic idle();
    drive_cpu(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_aux(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Record the effect of a granted command: writes update the reference, reads queue a response.
  task automatic note_grant(input logic src, input logic we, input logic be,
                            input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    if (we) begin
      ref_write(be, addr, wdata);
    end else begin
      e.src  = src;
      e.data = ref_read(be, addr);
      exp_q.push_back(e);
    end
  endtask

  // Called at negedge: match any rvalid against the scoreboard, then move to posedge+1.
  task automatic sb_cycle();
    exp_t        e;
    logic [31:0] got;
    if (cpu_rvalid === 1'b1 || aux_rvalid === 1'b1) begin
      n_compared++;
      got = (aux_rvalid === 1'b1) ? aux_rdata : cpu_rdata;
      if (cpu_rvalid === 1'b1 && aux_rvalid === 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL rvalid_both: got cpu_rvalid=1 aux_rvalid=1 expected single pulse");
      end else if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL rvalid_unexpected: got src=%0d data=%h expected no response",
                 aux_rvalid, got);
      end else begin
        e = exp_q.pop_front();
        if (e.src !== aux_rvalid || e.data !== got) begin
          n_mismatched++;
          $display("[TB] FAIL rdata: got src=%0d data=%h expected src=%0d data=%h",
                   aux_rvalid, got, e.src, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sb_cycle();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_compared++;
    if ({cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, mem_we, mem_be} !== 6'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, mem_we, mem_be});
    end
    n_compared++;
    if (mem_a !== 32'd0 || mem_wd !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mem_port: got a=%h wd=%h expected 0", mem_a, mem_wd);
    end
    n_compared++;
    if (cpu_rdata !== 32'd0 || aux_rdata !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_rdata: got cpu=%h aux=%h expected 0", cpu_rdata, aux_rdata);
    end
    drive_cpu(1'b1, 1'b1, 1'b0, 32'h10, 32'h1111_1111);
    #1;
    n_compared++;
    if (cpu_gnt !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_gnt: got %b expected 0", cpu_gnt);
    end
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cpu_write_read();
    drive_cpu(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    n_compared++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL wr_grant: got gnt=%b mem_we=%b expected gnt=1 mem_we=0", cpu_gnt, mem_we);
    end
    note_grant(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    sb_cycle();
    drive_cpu(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    n_compared++;
    if ({cpu_gnt, mem_we, mem_be, mem_a, mem_wd} !== {1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF}) begin
      n_mismatched++;
      $display("[TB] FAIL wr_port: got gnt=%b we=%b be=%b a=%h wd=%h expected 1 1 0 00000010 deadbeef",
               cpu_gnt, mem_we, mem_be, mem_a, mem_wd);
    end
    note_grant(1'b0, 1'b0, 1'b0, 32'h10, 32'd0);
    sb_cycle();
    idle();
    @(negedge clk);
    n_compared++;
    if (mem_we !== 1'b0 || mem_a !== 32'h10 || cpu_rvalid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rd_port: got we=%b a=%h rvalid=%b expected 0 00000010 0",
               mem_we, mem_a, cpu_rvalid);
    end
    sb_cycle();
    @(negedge clk);
    n_compared++;
    if (cpu_rvalid !== 1'b1 || aux_rvalid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rd_latency: got cpu_rvalid=%b aux_rvalid=%b expected 1 0",
               cpu_rvalid, aux_rvalid);
    end
    sb_cycle();
    drain(1);
  endtask

  task automatic test_aux_byte();
    drive_aux(1'b1, 1'b1, 1'b1, 32'h13, 32'hFFFF_FF5A);
    @(negedge clk);
    n_compared++;
    if (aux_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL aux_wr_gnt: got aux=%b cpu=%b expected 1 0", aux_gnt, cpu_gnt);
    end
    note_grant(1'b1, 1'b1, 1'b1, 32'h13, 32'hFFFF_FF5A);
    sb_cycle();
    drive_aux(1'b1, 1'b0, 1'b1, 32'h13, 32'd0);
    @(negedge clk);
    n_compared++;
    if (mem_we !== 1'b1 || mem_be !== 1'b1 || mem_a !== 32'h13) begin
      n_mismatched++;
      $display("[TB] FAIL aux_byte_port: got we=%b be=%b a=%h expected 1 1 00000013",
               mem_we, mem_be, mem_a);
    end
    note_grant(1'b1, 1'b0, 1'b1, 32'h13, 32'd0);
    sb_cycle();
    drive_aux(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_cpu(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    n_compared++;
    if (cpu_gnt !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL word_rd_gnt: got %b expected 1", cpu_gnt);
    end
    note_grant(1'b0, 1'b0, 1'b0, 32'h10, 32'd0);
    sb_cycle();
    idle();
    @(negedge clk);
    n_compared++;
    if (aux_rvalid !== 1'b1 || aux_rdata !== 32'h0000_005A) begin
      n_mismatched++;
      $display("[TB] FAIL aux_byte_rdata: got rvalid=%b data=%h expected 1 0000005a",
               aux_rvalid, aux_rdata);
    end
    sb_cycle();
    drain(2);
  endtask

  task automatic test_starvation();
    logic        exp_aux;
    logic [31:0] ca, aa;
    for (int i = 0; i < 15; i++) begin
      ca = 32'h40 + 32'(4 * (i % 8));
      aa = 32'h80 + 32'(4 * (i % 8));
      exp_aux = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
      drive_cpu(1'b1, 1'b0, 1'b0, ca, 32'd0);
      drive_aux(1'b1, 1'b0, 1'b0, aa, 32'd0);
      @(negedge clk);
      n_compared++;
      if ({cpu_gnt, aux_gnt} !== {~exp_aux, exp_aux}) begin
        n_mismatched++;
        $display("[TB] FAIL starve_pattern[%0d]: got cpu=%b aux=%b expected cpu=%b aux=%b",
                 i, cpu_gnt, aux_gnt, ~exp_aux, exp_aux);
      end
      note_grant(exp_aux, 1'b0, 1'b0, exp_aux ? aa : ca, 32'd0);
      sb_cycle();
    end
    idle();
    drain(3);
  endtask

  task automatic test_interleaved();
    logic        is_aux;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      is_aux = i[0];
      idle();
      if (is_aux) begin
        a = 32'h40 + 32'(i);
        drive_aux(1'b1, 1'b0, 1'b1, a, 32'd0);
      end else begin
        a = 32'h20 + 32'(4 * i);
        drive_cpu(1'b1, 1'b0, 1'b0, a, 32'd0);
      end
      @(negedge clk);
      n_compared++;
      if ({cpu_gnt, aux_gnt} !== {~is_aux, is_aux}) begin
        n_mismatched++;
        $display("[TB] FAIL interleave_gnt[%0d]: got cpu=%b aux=%b expected cpu=%b aux=%b",
                 i, cpu_gnt, aux_gnt, ~is_aux, is_aux);
      end
      note_grant(is_aux, 1'b0, is_aux, a, 32'd0);
      sb_cycle();
    end
    idle();
    drain(3);
  endtask

  task automatic test_back_to_back();
    drive_cpu(1'b1, 1'b1, 1'b0, 32'h30, 32'h0000_0001);
    @(negedge clk);
    note_grant(1'b0, 1'b1, 1'b0, 32'h30, 32'h0000_0001);
    sb_cycle();
    drive_cpu(1'b1, 1'b0, 1'b0, 32'h30, 32'd0);
    @(negedge clk);
    note_grant(1'b0, 1'b0, 1'b0, 32'h30, 32'd0);
    sb_cycle();
    drive_cpu(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_aux(1'b1, 1'b1, 1'b1, 32'h31, 32'h0000_0077);
    @(negedge clk);
    n_compared++;
    if (aux_gnt !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL raw_aux_gnt: got %b expected 1", aux_gnt);
    end
    note_grant(1'b1, 1'b1, 1'b1, 32'h31, 32'h0000_0077);
    sb_cycle();
    idle();
    drive_cpu(1'b1, 1'b0, 1'b0, 32'h30, 32'd0);
    @(negedge clk);
    note_grant(1'b0, 1'b0, 1'b0, 32'h30, 32'd0);
    sb_cycle();
    idle();
    drain(3);
  endtask

  task automatic test_reset_inflight();
    drive_cpu(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    sb_cycle();
    idle();
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({mem_we, mem_be, mem_a, mem_wd} !== 66'd0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_rd_port: got we=%b be=%b a=%h wd=%h expected all 0",
               mem_we, mem_be, mem_a, mem_wd);
    end
    @(negedge clk);
    sb_cycle();
    @(negedge clk);
    n_compared++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_rd_dropped: got rvalid=%b data=%h expected 0 0", cpu_rvalid, cpu_rdata);
    end
    sb_cycle();
    rst_n = 1'b1;
    drive_cpu(1'b1, 1'b1, 1'b0, 32'h34, 32'h1234_5678);
    @(negedge clk);
    sb_cycle();
    idle();
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (mem_we !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_wr_blocked: got mem_we=%b expected 0", mem_we);
    end
    @(negedge clk);
    sb_cycle();
    rst_n = 1'b1;
    drive_cpu(1'b1, 1'b0, 1'b0, 32'h34, 32'd0);
    @(negedge clk);
    n_compared++;
    if (cpu_gnt !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL fresh_gnt: got %b expected 1", cpu_gnt);
    end
    note_grant(1'b0, 1'b0, 1'b0, 32'h34, 32'd0);
    sb_cycle();
    idle();
    @(negedge clk);
    sb_cycle();
    @(negedge clk);
    n_compared++;
    if (cpu_rvalid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL fresh_rvalid: got %b expected 1", cpu_rvalid);
    end
    sb_cycle();
    drain(1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    $display("[TB] dmem_arbiter bench start, MAX_WAIT=%0d", MAX_WAIT);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_cpu_write_read();
    test_aux_byte();
    test_starvation();
    test_interleaved();
    test_back_to_back();
    test_reset_inflight();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL sb_drained: got %0d pending responses expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
